// File: rtl/led_bar_pkg.sv
// rtl/led_bar_pkg.sv - shared LED bar state encodings, count constants and index helper
package led_bar_pkg;

  // Owner / pointer index width; covers up to 8 requesters.
  localparam int IDX_W = 3;

  // Burst sequencing states shared by the LED bar family.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LIT2 = 3'd1,
    ST_LIT3 = 3'd2,
    ST_LIT5 = 3'd3,
    ST_GAP  = 3'd4
  } led_state_t;

  // Number of lit LEDs shown on the bar for each ramp step.
  localparam logic [2:0] Z_OFF = 3'b000;
  localparam logic [2:0] Z_2   = 3'b010;
  localparam logic [2:0] Z_3   = 3'b011;
  localparam logic [2:0] Z_5   = 3'b101;

  // Next index in cyclic order over n requesters (wraps n-1 -> 0).
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input int n);
    logic [IDX_W-1:0] last;
    last = IDX_W'(n - 1);
    return (idx >= last) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/led_bar_rr_sequencer_if.sv
// rtl/led_bar_rr_sequencer_if.sv - request/config and bar-status bundle for the sequencer
interface led_bar_rr_sequencer_if
  import led_bar_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DWELL_W = 8
);

  // Request side: level requests plus the per-step dwell setting.
  logic [N_REQ-1:0]   req;
  logic [DWELL_W-1:0] cfg_dwell;

  // Status side: ownership, LED count and end-of-burst pulses.
  logic [N_REQ-1:0]   grant;
  logic [IDX_W-1:0]   owner;
  logic               busy;
  logic [2:0]         z;
  logic               done;
  logic               abort;

  // Master drives requests (request sources / bench).
  modport master (
    output req, cfg_dwell,
    input  grant, owner, busy, z, done, abort
  );

  // Slave is the sequencer itself.
  modport slave (
    input  req, cfg_dwell,
    output grant, owner, busy, z, done, abort
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational cyclic-priority picker starting at a pointer
module rr_pick
  import led_bar_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [IDX_W-1:0] o_winner
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]   w_off;
  logic [IDX_W:0]     w_sum;

  // Rotate so that the pointer position lands on bit 0; the first set bit
  // of the rotated vector is then the cyclic winner's offset from the pointer.
  assign w_dbl = {i_req, i_req};
  assign w_rot = N_REQ'(w_dbl >> i_ptr);
  assign o_any = |i_req;

  // Lowest set bit of the rotated vector; scanning downward lets the lowest win.
  always_comb begin
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = IDX_W'(i);
      end
    end
  end

  // Map the offset back to an absolute requester index, modulo N_REQ.
  assign w_sum    = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_winner = (w_sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(N_REQ))
                                                 : w_sum[IDX_W-1:0];

endmodule

// File: rtl/led_bar_rr_sequencer.sv
// rtl/led_bar_rr_sequencer.sv - round-robin owner of the LED bar running a 0-2-3-5-0 ramp
module led_bar_rr_sequencer
  import led_bar_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DWELL_W = 8
) (
  input logic                    i_clock,
  input logic                    i_reset,
  led_bar_rr_sequencer_if.slave  bus
);

  led_state_t         r_state;
  logic [DWELL_W-1:0] r_cnt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [N_REQ-1:0]   r_grant;
  logic               r_busy;
  logic [2:0]         r_z;
  logic               r_done;
  logic               r_abort;

  logic               w_any;
  logic [IDX_W-1:0]   w_winner;
  logic [N_REQ-1:0]   w_win_grant;
  logic               w_owner_req;
  logic [IDX_W-1:0]   w_next_ptr;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  // Grant is one-hot of the owner, so masking req with it isolates req[owner].
  assign w_win_grant = N_REQ'(1) << w_winner;
  assign w_owner_req = |(bus.req & r_grant);
  assign w_next_ptr  = next_idx(r_owner, N_REQ);

  // Burst FSM: grant, ramp through the lit steps with dwell, close via GAP or abort.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_z     <= Z_OFF;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_LIT2;
            r_grant <= w_win_grant;
            r_owner <= w_winner;
            r_busy  <= 1'b1;
            r_z     <= Z_2;
            r_cnt   <= bus.cfg_dwell;
          end
        end
        ST_LIT2, ST_LIT3, ST_LIT5: begin
          if (!w_owner_req) begin
            // Owner let go: abort takes precedence even on the final step.
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_z     <= Z_OFF;
            r_abort <= 1'b1;
            r_ptr   <= w_next_ptr;
          end else if (r_cnt == '0) begin
            case (r_state)
              ST_LIT2: begin
                r_state <= ST_LIT3;
                r_z     <= Z_3;
                r_cnt   <= bus.cfg_dwell;
              end
              ST_LIT3: begin
                r_state <= ST_LIT5;
                r_z     <= Z_5;
                r_cnt   <= bus.cfg_dwell;
              end
              default: begin
                r_state <= ST_GAP;
                r_grant <= '0;
                r_busy  <= 1'b0;
                r_z     <= Z_OFF;
                r_done  <= 1'b1;
                r_ptr   <= w_next_ptr;
              end
            endcase
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          // Forced dark cycle between bursts; requests are not looked at here.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant = r_grant;
  assign bus.owner = r_owner;
  assign bus.busy  = r_busy;
  assign bus.z     = r_z;
  assign bus.done  = r_done;
  assign bus.abort = r_abort;

endmodule
